// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, behind a
// start/busy/done handshake. Result appears WIDTH cycles after the accepting edge.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;

    // Full adder built from two half adders with their carries ORed.
    always_comb begin
        ha1_s = sa_q[0] ^ sb_q[0];
        ha1_c = sa_q[0] & sb_q[0];
        fa_s  = ha1_s ^ carry_q;
        ha2_c = ha1_s & carry_q;
        fa_c  = ha1_c | ha2_c;
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d             = sa_q >> 1;
                sb_d             = sb_q >> 1;
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fa_s;
                carry_d          = fa_c;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so outputs come straight off flops.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, table vectors,
// handshake corner cases and a back-to-back random run against a scoreboard queue.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    int errors = 0;
    int checks = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vec8[6];
    vec_t vec1[8];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop8(input string name);
        logic [8:0] e;
        if (q8.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q8.pop_front();
            check({name, "_sum"}, {24'd0, sum8}, {24'd0, e[7:0]});
            check({name, "_cout"}, {31'd0, cout8}, {31'd0, e[8]});
        end
    endtask

    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic ec, input bit poke);
        logic [7:0] prev_sum;
        int         cyc;
        bit         changed;
        bit         overlap;
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check("accept_busy", {31'd0, busy8}, 32'd1);
        q8.push_back({ec, es});
        prev_sum = sum8; cyc = 0; changed = 0; overlap = 0;
        while (!done8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (poke) begin
                start8 = (cyc == 3);
                if (cyc == 3) a8 = 8'h11;
            end
            if (busy8 && done8) overlap = 1;
            if (!done8 && sum8 !== prev_sum) changed = 1;
        end
        start8 = 1'b0;
        check("latency8", cyc, 32'd8);
        check("sum_hold_in_run", {31'd0, changed}, 32'd0);
        check("busy_done_overlap", {31'd0, overlap}, 32'd0);
        if (done8) pop8("op8");
        @(negedge clk);
        check("done_single_pulse", {30'd0, busy8, done8}, 32'd0);
    endtask

    initial begin
        int         cyc;
        bit         seen;
        logic [7:0] ra, rb;
        logic       rc;
        logic [1:0] e1;

        vec8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vec8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vec8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vec8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vec8[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vec8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vec1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        vec1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0};
        vec1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0};
        vec1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
        vec1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
        vec1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1};
        vec1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1};
        vec1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};

        #1 rst = 1'b1;
        #1;
        check("reset_outputs8", {22'd0, busy8, done8, sum8, cout8}, 32'd0);
        check("reset_outputs1", {28'd0, busy1, done1, sum1, cout1}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op8(vec8[i].a, vec8[i].b, vec8[i].cin, vec8[i].es, vec8[i].ec, 1'b0);

        // Start pulse during RUN must be ignored.
        do_op8(8'h22, 8'h33, 1'b0, 8'h55, 1'b0, 1'b1);
        do_op8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-RUN abandons the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {22'd0, busy8, done8, sum8, cout8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1;
        end
        check("no_done_after_reset", {31'd0, seen}, 32'd0);
        do_op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Back-to-back with start held high; operands change only in DONE.
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        start8 = 1'b1; a8 = ra; b8 = rb; cin8 = rc;
        @(negedge clk);
        q8.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        for (int i = 0; i < 1000; i++) begin
            cyc = 0;
            while (!done8 && cyc < 20) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
            check("b2b_interval", cyc, 32'd8);
            if (done8) pop8("b2b");
            if (i < 999) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                a8 = ra; b8 = rb; cin8 = rc;
                @(negedge clk);
                if (busy8 !== 1'b1) check("b2b_reaccept", {31'd0, busy8}, 32'd1);
                q8.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_scoreboard_drained", q8.size(), 32'd0);

        // WIDTH = 1 instance.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start1 = 1'b1; a1 = vec1[i].a[0:0]; b1 = vec1[i].b[0:0]; cin1 = vec1[i].cin;
            @(negedge clk);
            start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            q1.push_back({vec1[i].ec, vec1[i].es[0]});
            @(negedge clk);
            check("w1_done_latency", {31'd0, done1}, 32'd1);
            if (done1 && q1.size() > 0) begin
                e1 = q1.pop_front();
                check("w1_result", {30'd0, cout1, sum1}, {30'd0, e1});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first N-bit adder built around a single full-adder cell, which is two half-adders with the carries ORed, plus a carry flip-flop. It is the addition counterpart of the team's full-subtractor work. It trades WIDTH cycles of latency for one-bit datapath area. It sits behind a simple start/done handshake so a controller can issue back-to-back additions.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an addition; honoured only when busy = 0.
- a  input  WIDTH  augend; sampled on the accepting edge only.
- b  input  WIDTH  addend; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result of a + b + cin, modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

## Operation
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE, start = 1:
  - load shift registers sa ← a and sb ← b;
  - carry flop ← cin, bit counter ← 0, accumulator ← 0;
  - go to RUN.
- IDLE, start = 0: hold.
- RUN, each cycle:
  - s = sa[0] ^ sb[0] ^ carry;
  - c = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & carry);
  - shift sa and sb right by one;
  - shift s into the accumulator MSB (accumulator shifts right);
  - carry ← c, counter += 1.
- RUN, on the cycle that processes bit WIDTH-1:
  - sum ← the completed accumulator;
  - cout ← final c;
  - go to DONE.
- DONE: lasts one cycle.
  - start = 1: accept exactly as in IDLE and go to RUN.
  - start = 0: go to IDLE.
- start while in RUN: ignored, with no effect on the operation in flight or on any later one.
- sum and cout change only on completion. They hold the previous result throughout RUN and until the next completion.
- a, b and cin may change freely after the accepting edge.
- Counter width is clog2(WIDTH) + 1 bits. There is no wrap-around issue: the counter is cleared on every accept.
- WIDTH = 1: RUN lasts exactly one cycle.

## Timing
- Reset (asynchronous assert, any state): state = IDLE, busy = 0, done = 0, sum = 0, cout = 0; internal shift registers, carry and counter = 0.
- Reset mid-RUN: the operation is abandoned and no done pulse is produced.
- Deassertion of rst is synchronised externally. The first edge after release may accept a start.
- Accepting edge E0 (start = 1, busy = 0): busy = 1 from E0.
- Bit i is processed at edge E(i+1).
- After edge E(WIDTH):
  - busy = 0, done = 1, sum and cout valid;
  - latency from start to done = WIDTH cycles.
- done is high for exactly one cycle.
- busy = 0 in IDLE and DONE; busy = 1 only in RUN.
- busy and done are never high together.
- Back-to-back: start held high continuously yields a result every WIDTH + 1 cycles. Each completion produces one done pulse.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH = 8: a = 0x5A, b = 0x3C, cin = 0 → done exactly 8 cycles after the accepting edge; sum = 0x96, cout = 0.
- WIDTH = 8: a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1. Then a = 0xFF, b = 0xFF, cin = 1 → sum = 0xFF, cout = 1.
- Operation running: pulse start with a = 0x11 during RUN → ignored. The result still matches the original operands, a single done pulse is produced, and sum is unchanged during RUN.
- Assert rst at the 4th RUN cycle → busy, done, sum and cout drop to 0 immediately. No done follows. A fresh start of 0x01 + 0x02 then gives sum = 0x03.
- start held high with a new operand pair presented each DONE cycle → successive results appear every 9 cycles. Check 1000 random operand/cin triples against a + b + cin.
- WIDTH = 1: all 8 combinations of a, b and cin → done 1 cycle after accept; {cout, sum} = a + b + cin.
